cpu_trace_monitor: RTL and testbench
====================================

// Module: cpu_trace_monitor
// PURPOSE
//   Synthesizable run-time trace and watchpoint unit for the single-cycle MIPS core.
//   Taps PC, instruction, register-file write and data-memory write strobes each cycle.
//   Filters the taps into typed trace entries and buffers them in a DEPTH-entry FIFO,
//   which is drained over a valid/ready port.
//   Raises a sticky halt request on a PC or memory-address watchpoint hit.
//   Replaces per-cycle $display dumps in benches and on-board debug.
// PARAMETERS
//   DEPTH   16  trace FIFO entries; power of 2, >=2
//   NUM_WP  4   number of watchpoint comparators, 1..8
//   POST    8   entries captured after trigger in mode TRIG, >=1
//   CNT_W   32  width of cycle_cnt
// PORTS
//   Clk        in   1         core clock
//   Reset      in   1         asynchronous, active-high reset
//   en         in   1         core advanced this cycle; taps are valid only when en=1
//   clr        in   1         sync clear: flush FIFO, zero counters/flags, FSM->ARMED
//   mode       in   2         00 OFF, 01 ALL (every instr), 10 WR (writes only), 11 TRIG
//   pc         in   32        PC of the current instruction
//   instr      in   32        current instruction word
//   reg_wr     in   1         register-file write strobe
//   reg_rd     in   5         destination register
//   reg_wdata  in   32        register write data
//   mem_wr     in   1         data-memory store strobe (any MemWr width)
//   mem_addr   in   32        store address
//   mem_wdata  in   32        store data
//   wp_addr    in   NUM_WP*32 watchpoint addresses; slot i = [32*i+:32]
//   wp_en      in   NUM_WP    per-slot enable
//   tr_valid   out  1         FIFO head valid
//   tr_ready   in   1         consumer accepts head when tr_valid&tr_ready
//   tr_data    out  98        {type[1:0], pc[31:0], addr[31:0], data[31:0]}
//   overflow   out  1         sticky: an event was dropped
//   drop_cnt   out  16        dropped-event count, saturates at 16'hFFFF
//   halt_req   out  1         sticky watchpoint hit
//   trig_state out  2         FSM state
//   cycle_cnt  out  CNT_W     en cycles since reset/clr; wraps
// BEHAVIOUR
//   Reset: all outputs 0; FIFO empty; FSM=ARMED; tr_data=0.
//   Reset mid-drain: FIFO contents are lost.
//   Event (en=1), one per cycle, priority mem > reg > instr:
//     - mem_wr: type 10, addr=mem_addr, data=mem_wdata.
//     - reg_wr: type 01, addr={27'b0,reg_rd}, data=reg_wdata.
//       If mem_wr=1 in the same cycle, the reg event is dropped.
//     - instr-only: type 00, addr=instr, data=0.
//   Mode filtering:
//     - OFF: no pushes.
//     - ALL: every event.
//     - WR: types 01/10 only.
//     - TRIG: WR filtering, gated by the FSM.
//   Watchpoint hit, slot i: wp_en[i] & en & (pc==wp_addr[i] | (mem_wr & mem_addr==wp_addr[i])).
//     - Matched in every mode except OFF.
//     - halt_req rises the cycle after the hit; holds until clr/Reset.
//   FSM (advances in TRIG only; other modes hold state):
//     - ARMED(00) -> CAPT(01) on a hit.
//     - CAPT(01) -> DONE(10) after POST accepted pushes.
//     - DONE(10) -> ARMED only via clr.
//     - The hit cycle's own event is the first CAPT entry.
//     - Dropped events count toward POST.
//     - Changing mode does not reset the FSM.
//   FIFO:
//     - Push is registered; tr_valid rises 1 cycle after a push into an empty FIFO (no fall-through).
//     - tr_data is stable while tr_valid=1 and tr_ready=0.
//     - Full with no pop: event dropped; overflow<=1; drop_cnt++ (saturating).
//     - Full with pop in the same cycle: push accepted, occupancy unchanged.
//     - Empty: a pop is ignored.
//     - Pointers wrap modulo DEPTH.
//     - A collision drop (reg lost to mem) also increments drop_cnt but does not set overflow.
//   clr priority:
//     - clr beats a simultaneous push/pop/hit.
//     - All state is cleared next cycle; cycle_cnt=0.
//   cycle_cnt: +1 on each en=1 cycle.
// TESTING
//   1. mode=ALL, 3 en cycles with pc=0,4,8, no writes.
//      -> 3 type-00 entries, in order, with pc 0/4/8.
//   2. mode=WR, reg_wr rd=16 wdata=32'hFFFF0000, then mem_wr addr=FFE8 data=5.
//      -> entries {01,pc,0x10,FFFF0000} then {10,pc,FFE8,5}.
//   3. tr_ready=0, mode=ALL, DEPTH+3 events.
//      -> DEPTH entries kept, overflow=1, drop_cnt=3.
//      -> Then pop+push while full: count stays DEPTH.
//   4. mode=TRIG, POST=8, wp_addr[0]=0x20 en.
//      -> pc=0x20 hit: halt_req next cycle, state CAPT.
//      -> Exactly 8 entries, then state DONE; writes in ARMED are not captured.
//   5. reg_wr & mem_wr in the same cycle.
//      -> single type-10 entry, drop_cnt=1, overflow=0.
//   6. Reset asserted asynchronously mid-capture, and clr coincident with a hit.
//      -> All outputs 0, FSM ARMED, halt_req stays 0.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
//   Run-time trace and watchpoint unit for the single-cycle MIPS core.
//   Each en cycle, the PC, instruction, register-file write and store taps are
//   reduced to one typed trace entry and filtered by mode. The surviving entries
//   go into a DEPTH-entry FIFO that a consumer drains over valid/ready.
//   A PC or store-address watchpoint hit sets a sticky halt request. In TRIG mode
//   the hit also starts a capture window of POST entries.
// Ports
//   Clk, Reset        clock, asynchronous active-high reset
//   en, clr           core-advanced qualifier, synchronous clear
//   mode              00 OFF, 01 ALL, 10 WR, 11 TRIG
//   pc, instr         current instruction taps
//   reg_wr/rd/wdata   register-file write taps
//   mem_wr/addr/wdata data-memory store taps
//   wp_addr, wp_en    watchpoint comparators (slot i = wp_addr[32*i+:32])
//   tr_valid/ready    trace output handshake; tr_data = {type, pc, addr, data}
//   overflow          sticky; set when an event is lost because the FIFO is full
//   drop_cnt          count of lost events, saturating
//   halt_req          sticky watchpoint hit
//   trig_state        capture FSM state
//   cycle_cnt         count of en cycles since reset or clr
// Handshake: the head entry moves to the consumer on a rising Clk edge where
//   tr_valid and tr_ready are both 1. tr_valid does not depend on tr_ready.
//   tr_data holds steady while tr_valid=1 and tr_ready=0.
module cpu_trace_monitor #(
  parameter int DEPTH  = 16,
  parameter int NUM_WP = 4,
  parameter int POST   = 8,
  parameter int CNT_W  = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [1:0]            mode,
  input  logic [31:0]           pc,
  input  logic [31:0]           instr,
  input  logic                  reg_wr,
  input  logic [4:0]            reg_rd,
  input  logic [31:0]           reg_wdata,
  input  logic                  mem_wr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [NUM_WP*32-1:0]  wp_addr,
  input  logic [NUM_WP-1:0]     wp_en,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [97:0]           tr_data,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic                  halt_req,
  output logic [1:0]            trig_state,
  output logic [CNT_W-1:0]      cycle_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(POST + 1);

  typedef enum logic [1:0] {
    ST_ARMED = 2'b00,
    ST_CAPT  = 2'b01,
    ST_DONE  = 2'b10
  } trig_state_e;

  trig_state_e      state_q, state_d;
  logic [PW-1:0]    post_cnt_q, post_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [97:0]      mem_q [DEPTH];

  logic [1:0]  ev_type;
  logic [31:0] ev_addr, ev_data;
  logic        wp_hit, mode_ok, push_req, push_ok, pop, full;
  logic        fifo_drop, coll_drop;
  logic [16:0] drop_sum;

  // Event selection: a store wins over a register write, which wins over a bare instruction.
  always_comb begin
    ev_type = 2'b00;
    ev_addr = instr;
    ev_data = 32'h0;
    if (mem_wr) begin
      ev_type = 2'b10;
      ev_addr = mem_addr;
      ev_data = mem_wdata;
    end else if (reg_wr) begin
      ev_type = 2'b01;
      ev_addr = {27'b0, reg_rd};
      ev_data = reg_wdata;
    end
  end

  // Watchpoints are live in every mode except OFF.
  always_comb begin
    wp_hit = 1'b0;
    for (int i = 0; i < NUM_WP; i++) begin
      if (wp_en[i] && (pc == wp_addr[32*i +: 32] ||
                       (mem_wr && mem_addr == wp_addr[32*i +: 32])))
        wp_hit = 1'b1;
    end
    wp_hit = wp_hit & en & (mode != 2'b00);
  end

  // In TRIG, the hit cycle opens the window, so its own event is already eligible.
  always_comb begin
    mode_ok = 1'b0;
    case (mode)
      2'b01:   mode_ok = 1'b1;
      2'b10:   mode_ok = (ev_type != 2'b00);
      2'b11:   mode_ok = (ev_type != 2'b00) &&
                         (state_q == ST_CAPT || (state_q == ST_ARMED && wp_hit));
      default: mode_ok = 1'b0;
    endcase
    push_req = en & mode_ok;
  end

  // FIFO bookkeeping. A push into a full FIFO is still taken when the head leaves in the same cycle.
  always_comb begin
    tr_valid  = (count_q != '0);
    full      = (count_q == (AW + 1)'(DEPTH));
    pop       = tr_valid & tr_ready;
    push_ok   = push_req & (~full | pop);
    fifo_drop = push_req & full & ~pop;
    // The register write lost to a simultaneous store counts as a drop only when the store entry is produced.
    coll_drop = push_req & mem_wr & reg_wr;
    drop_sum  = {1'b0, drop_cnt_q} + 17'(fifo_drop) + 17'(coll_drop);
    tr_data   = tr_valid ? mem_q[rd_ptr_q] : 98'h0;
  end

  // Capture FSM plus all next-state values. clr has priority over every other update.
  always_comb begin
    state_d     = state_q;
    post_cnt_d  = post_cnt_q;
    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    overflow_d  = overflow_q | fifo_drop;
    drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    halt_d      = halt_q | wp_hit;
    cycle_cnt_d = cycle_cnt_q + CNT_W'(en);
    if (mode == 2'b11) begin
      case (state_q)
        ST_ARMED: if (wp_hit) begin
          state_d    = ST_CAPT;
          post_cnt_d = PW'(push_req);
          if (push_req && (PW'(1) == PW'(POST))) begin
            state_d    = ST_DONE;
            post_cnt_d = '0;
          end
        end
        ST_CAPT: if (push_req) begin
          // Entries lost to a full FIFO still use up the window.
          if ((post_cnt_q + PW'(1)) == PW'(POST)) begin
            state_d    = ST_DONE;
            post_cnt_d = '0;
          end else begin
            post_cnt_d = post_cnt_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
    if (clr) begin
      state_d     = ST_ARMED;
      post_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      drop_cnt_d  = 16'h0;
      halt_d      = 1'b0;
      cycle_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_ARMED;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 16'h0;
      halt_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      halt_q      <= halt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Storage needs no reset: tr_data is masked whenever the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push_ok && !clr)
      mem_q[wr_ptr_q] <= {ev_type, pc, ev_addr, ev_data};
  end

  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign halt_req   = halt_q;
  assign trig_state = state_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
module tb_cpu_trace_monitor;

  localparam int DEPTH  = 16;
  localparam int NUM_WP = 4;
  localparam int POST   = 8;
  localparam int CNT_W  = 32;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 en = 1'b0, clr = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic [31:0]          pc = '0, instr = '0;
  logic                 reg_wr = 1'b0;
  logic [4:0]           reg_rd = '0;
  logic [31:0]          reg_wdata = '0;
  logic                 mem_wr = 1'b0;
  logic [31:0]          mem_addr = '0, mem_wdata = '0;
  logic [NUM_WP*32-1:0] wp_addr = '0;
  logic [NUM_WP-1:0]    wp_en = '0;
  logic                 tr_valid, tr_ready = 1'b0;
  logic [97:0]          tr_data;
  logic                 overflow;
  logic [15:0]          drop_cnt;
  logic                 halt_req;
  logic [1:0]           trig_state;
  logic [CNT_W-1:0]     cycle_cnt;

  logic [97:0] exp_q[$];
  int total = 0;
  int bad = 0;

  cpu_trace_monitor #(.DEPTH(DEPTH), .NUM_WP(NUM_WP), .POST(POST), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .en(en), .clr(clr), .mode(mode),
    .pc(pc), .instr(instr), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wp_addr(wp_addr), .wp_en(wp_en),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
    .overflow(overflow), .drop_cnt(drop_cnt), .halt_req(halt_req),
    .trig_state(trig_state), .cycle_cnt(cycle_cnt)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  function automatic logic [97:0] mk(input logic [1:0] t, input logic [31:0] p,
                                     input logic [31:0] a, input logic [31:0] d);
    return {t, p, a, d};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] p, input logic [31:0] ins,
                    input logic rw, input logic [4:0] rd, input logic [31:0] rdat,
                    input logic mw, input logic [31:0] ma, input logic [31:0] md);
    pc = p; instr = ins;
    reg_wr = rw; reg_rd = rd; reg_wdata = rdat;
    mem_wr = mw; mem_addr = ma; mem_wdata = md;
    en = 1'b1;
    step();
    en = 1'b0; reg_wr = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // scoreboard: pop one expected entry per accepted handshake
  task automatic drain(input int max_cyc);
    logic [97:0] e;
    tr_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (tr_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_entry", 128'(tr_data), 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("entry", 128'(tr_data), 128'(e));
        end
        step();
      end else if (exp_q.size() == 0) begin
        break;
      end else begin
        step();
      end
    end
    tr_ready = 1'b0;
    chk("drain_left", 128'(exp_q.size()), 128'h0);
    chk("drain_empty", 128'(tr_valid), 128'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [97:0] e;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // reset state
    chk("rst_valid", 128'(tr_valid), 128'h0);
    chk("rst_data", 128'(tr_data), 128'h0);
    chk("rst_ovf", 128'(overflow), 128'h0);
    chk("rst_drop", 128'(drop_cnt), 128'h0);
    chk("rst_halt", 128'(halt_req), 128'h0);
    chk("rst_state", 128'(trig_state), 128'h0);
    chk("rst_cycle", 128'(cycle_cnt), 128'h0);

    // ALL mode: three instruction-only entries
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      p = 32'(i * 4);
      exp_q.push_back(mk(2'b00, p, 32'h2000_0000 + 32'(i), 32'h0));
      ev(p, 32'h2000_0000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (i == 0) chk("valid_latency", 128'(tr_valid), 128'h1);
    end
    chk("cycle_cnt3", 128'(cycle_cnt), 128'h3);
    drain(10);

    // WR mode: instruction-only filtered, reg then mem kept
    mode = 2'b10;
    ev(32'h100, 32'hAAAA, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("wr_filter", 128'(tr_valid), 128'h0);
    exp_q.push_back(mk(2'b01, 32'h104, 32'h10, 32'hFFFF0000));
    ev(32'h104, 32'hBBBB, 1'b1, 5'd16, 32'hFFFF0000, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(mk(2'b10, 32'h108, 32'hFFE8, 32'h5));
    ev(32'h108, 32'hCCCC, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFE8, 32'h5);
    drain(10);

    // overflow: DEPTH+3 events with no consumer
    mode = 2'b01;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i < DEPTH) exp_q.push_back(mk(2'b00, 32'(i * 4), 32'h3000 + 32'(i), 32'h0));
      ev(32'(i * 4), 32'h3000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    end
    chk("ovf_set", 128'(overflow), 128'h1);
    chk("ovf_drop3", 128'(drop_cnt), 128'h3);
    // pop and push together while full: head leaves, new entry accepted
    tr_ready = 1'b1;
    e = exp_q.pop_front();
    chk("full_head", 128'(tr_data), 128'(e));
    exp_q.push_back(mk(2'b00, 32'h500, 32'h3FFF, 32'h0));
    ev(32'h500, 32'h3FFF, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tr_ready = 1'b0;
    chk("full_popush_drop", 128'(drop_cnt), 128'h3);
    // one more push must now be dropped if occupancy is still DEPTH
    ev(32'h504, 32'h4000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("still_full_drop", 128'(drop_cnt), 128'h4);
    drain(DEPTH + 5);
    do_clr();
    chk("clr_ovf", 128'(overflow), 128'h0);
    chk("clr_drop", 128'(drop_cnt), 128'h0);
    chk("clr_cycle", 128'(cycle_cnt), 128'h0);

    // reg and mem in the same cycle
    mode = 2'b10;
    exp_q.push_back(mk(2'b10, 32'h40, 32'h2000, 32'h99));
    ev(32'h40, 32'h1, 1'b1, 5'd7, 32'h77, 1'b1, 32'h2000, 32'h99);
    chk("coll_drop", 128'(drop_cnt), 128'h1);
    chk("coll_ovf", 128'(overflow), 128'h0);
    drain(10);
    do_clr();

    // TRIG mode capture window
    mode = 2'b11;
    wp_addr = {96'h0, 32'h20};
    wp_en = 4'b0001;
    ev(32'h10, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 32'h0);
    ev(32'h14, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h1000, 32'h44);
    chk("armed_state", 128'(trig_state), 128'h0);
    chk("armed_halt", 128'(halt_req), 128'h0);
    chk("armed_nocap", 128'(tr_valid), 128'h0);
    exp_q.push_back(mk(2'b01, 32'h20, 32'h1, 32'hA0));
    ev(32'h20, 32'h0, 1'b1, 5'd1, 32'hA0, 1'b0, 32'h0, 32'h0);
    chk("hit_halt", 128'(halt_req), 128'h1);
    chk("hit_state", 128'(trig_state), 128'h1);
    ev(32'h24, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= POST - 1; k++) begin
      p = 32'h28 + 32'(4 * k);
      if (k % 2 == 1) begin
        exp_q.push_back(mk(2'b01, p, 32'(k), 32'(k * 17)));
        ev(p, 32'h0, 1'b1, 5'(k), 32'(k * 17), 1'b0, 32'h0, 32'h0);
      end else begin
        exp_q.push_back(mk(2'b10, p, 32'h1000 + 32'(4 * k), 32'(k)));
        ev(p, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h1000 + 32'(4 * k), 32'(k));
      end
      if (k == POST - 2) chk("capt_state", 128'(trig_state), 128'h1);
    end
    chk("done_state", 128'(trig_state), 128'h2);
    ev(32'h100, 32'h0, 1'b1, 5'd9, 32'h9, 1'b0, 32'h0, 32'h0);
    chk("done_hold", 128'(trig_state), 128'h2);
    drain(POST + 6);
    do_clr();
    chk("clr_state", 128'(trig_state), 128'h0);
    chk("clr_halt", 128'(halt_req), 128'h0);

    // asynchronous reset mid-capture
    ev(32'h20, 32'h0, 1'b1, 5'd2, 32'h2, 1'b0, 32'h0, 32'h0);
    ev(32'h30, 32'h0, 1'b1, 5'd3, 32'h3, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_valid", 128'(tr_valid), 128'h1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_valid", 128'(tr_valid), 128'h0);
    chk("arst_data", 128'(tr_data), 128'h0);
    chk("arst_halt", 128'(halt_req), 128'h0);
    chk("arst_state", 128'(trig_state), 128'h0);
    chk("arst_cycle", 128'(cycle_cnt), 128'h0);
    #1 Reset = 1'b0;

    // clr coincident with a hit
    pc = 32'h20; reg_wr = 1'b1; reg_rd = 5'd4; reg_wdata = 32'h4;
    en = 1'b1; clr = 1'b1;
    step();
    en = 1'b0; clr = 1'b0; reg_wr = 1'b0;
    chk("clrhit_halt", 128'(halt_req), 128'h0);
    chk("clrhit_state", 128'(trig_state), 128'h0);
    chk("clrhit_valid", 128'(tr_valid), 128'h0);
    step();
    chk("clrhit_hold", 128'(halt_req), 128'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
